// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: redirect/stall controls in, pmem address/data, IF/ID outputs.
// master = fetch stage, slave = pipeline/pmem side.
interface instr_fetch_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
);
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] pmem_addr;
  logic [DATA_W-1:0] pmem_dout;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic [ADDR_W-1:0] if_pc_plus1;
  logic              if_valid;

  modport master (
    input  stall, branch_taken, branch_target, pmem_dout,
    output pmem_addr, if_instr, if_pc, if_pc_plus1, if_valid
  );

  modport slave (
    output stall, branch_taken, branch_target, pmem_dout,
    input  pmem_addr, if_instr, if_pc, if_pc_plus1, if_valid
  );
endinterface

// File: rtl/instr_fetch.sv
// MIPS IF stage: owns the PC, drives sync-read pmem, fills the IF/ID register.
// Define BRANCH_DELAY_SLOT_EN for MIPS delay-slot semantics (default: bubble on branch).
module instr_fetch #(
  parameter int unsigned          ADDR_W    = 11,
  parameter int unsigned          DATA_W    = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
  parameter logic [DATA_W-1:0]    NOP_INSTR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  instr_fetch_if.master   bus
);

  logic [ADDR_W-1:0] pc;
  logic              fvalid;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = pc + 1'b1;

`ifdef BRANCH_DELAY_SLOT_EN
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_target;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;

  // A branch seen during a stall is parked until the delay slot can be captured.
  always_comb begin
    redirect        = !bus.stall && (bus.branch_taken || pend_valid);
    redirect_target = bus.branch_taken ? bus.branch_target : pend_target;
  end

  always_comb begin
    next_pc = pc_inc;
    if (redirect)       next_pc = redirect_target;
    else if (bus.stall) next_pc = pc;
    else if (!fvalid)   next_pc = pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (bus.branch_taken && bus.stall) begin
      pend_valid  <= 1'b1;
      pend_target <= bus.branch_target;
    end else if (!bus.stall) begin
      pend_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.if_instr    <= NOP_INSTR;
      bus.if_pc       <= '0;
      bus.if_pc_plus1 <= '0;
      bus.if_valid    <= 1'b0;
    end else if (!bus.stall) begin
      bus.if_instr    <= bus.pmem_dout;
      bus.if_pc       <= pc;
      bus.if_pc_plus1 <= pc_inc;
      bus.if_valid    <= fvalid;
    end
  end
`else
  always_comb begin
    next_pc = pc_inc;
    if (bus.branch_taken) next_pc = bus.branch_target;
    else if (bus.stall)   next_pc = pc;
    else if (!fvalid)     next_pc = pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.if_instr    <= NOP_INSTR;
      bus.if_pc       <= '0;
      bus.if_pc_plus1 <= '0;
      bus.if_valid    <= 1'b0;
    end else if (bus.branch_taken) begin
      bus.if_instr    <= NOP_INSTR;
      bus.if_valid    <= 1'b0;
    end else if (!bus.stall) begin
      bus.if_instr    <= bus.pmem_dout;
      bus.if_pc       <= pc;
      bus.if_pc_plus1 <= pc_inc;
      bus.if_valid    <= fvalid;
    end
  end
`endif

  // Forced during reset so pmem sees RESET_PC regardless of a stray branch_taken.
  assign bus.pmem_addr = rst_n ? next_pc : RESET_PC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      fvalid <= 1'b0;
    end else begin
      pc     <= next_pc;
      fvalid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a sync-read pmem model holding mem[i]=32'h1000_0000+i.
module tb_instr_fetch;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  instr_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  instr_fetch #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RESET_PC (11'd0),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.pmem_dout <= 32'h1000_0000 + 32'(bus.pmem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [10:0] pc, input logic [10:0] pc1, input logic vld);
    check({tag, "_instr"}, bus.if_instr, instr);
    check({tag, "_pc"},    32'(bus.if_pc), 32'(pc));
    check({tag, "_pc1"},   32'(bus.if_pc_plus1), 32'(pc1));
    check({tag, "_valid"}, 32'(bus.if_valid), 32'(vld));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = '0;
    bus.pmem_dout = '0;

    // Test 1: reset state, then startup latency
    #3;
    check("rst_addr", 32'(bus.pmem_addr), 32'd0);
    step();
    check_ifid("rst", 32'h0, 11'd0, 11'd0, 1'b0);
    #2 rst_n = 1'b1;
    step();
    check("e1_valid", 32'(bus.if_valid), 32'd0);
    step();
    check_ifid("e2", 32'h1000_0000, 11'd0, 11'd1, 1'b1);
    step();
    check_ifid("e3", 32'h1000_0001, 11'd1, 11'd2, 1'b1);
    step();
    step();
    step();
    check_ifid("e6", 32'h1000_0004, 11'd4, 11'd5, 1'b1);
    check("e6_addr", 32'(bus.pmem_addr), 32'd6);

    // Test 2: stall at pc=5
    bus.stall = 1'b1;
    #1 check("stall_addr0", 32'(bus.pmem_addr), 32'd5);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", 32'(bus.pmem_addr), 32'd5);
      check("stall_instr", bus.if_instr, 32'h1000_0004);
    end
    bus.stall = 1'b0;
    #1 check("unstall_addr", 32'(bus.pmem_addr), 32'd6);
    step();
    check_ifid("unstall", 32'h1000_0005, 11'd5, 11'd6, 1'b1);
    step();
    check("pre_br_pc", 32'(bus.if_pc), 32'd6);

`ifdef BRANCH_DELAY_SLOT_EN
    // Test 5: branch at pc=7 with stall in the same cycle
    bus.branch_taken = 1'b1;
    bus.branch_target = 11'h100;
    bus.stall = 1'b1;
    step();
    check_ifid("ds_hold", 32'h1000_0006, 11'd6, 11'd7, 1'b1);
    bus.branch_taken = 1'b0;
    bus.stall = 1'b0;
    #1 check("ds_addr", 32'(bus.pmem_addr), 32'h100);
    step();
    check_ifid("ds_slot", 32'h1000_0007, 11'd7, 11'd8, 1'b1);
    step();
    check_ifid("ds_tgt", 32'h1000_0100, 11'h100, 11'h101, 1'b1);
`else
    // Test 3: branch at pc=7; bubble even with stall asserted
    bus.branch_taken = 1'b1;
    bus.branch_target = 11'h100;
    bus.stall = 1'b1;
    #1 check("br_addr", 32'(bus.pmem_addr), 32'h100);
    step();
    check("br_valid", 32'(bus.if_valid), 32'd0);
    check("br_instr", bus.if_instr, 32'h0);
    bus.branch_taken = 1'b0;
    bus.stall = 1'b0;
    step();
    check_ifid("br_tgt", 32'h1000_0100, 11'h100, 11'h101, 1'b1);
`endif

    // Test 4: branch to 2046 and wrap
    bus.branch_taken = 1'b1;
    bus.branch_target = 11'd2046;
    step();
`ifdef BRANCH_DELAY_SLOT_EN
    check("wbr_valid", 32'(bus.if_valid), 32'd1);
    check("wbr_pc", 32'(bus.if_pc), 32'h101);
`else
    check("wbr_valid", 32'(bus.if_valid), 32'd0);
`endif
    bus.branch_taken = 1'b0;
    step();
    check_ifid("w2046", 32'h1000_07FE, 11'd2046, 11'd2047, 1'b1);
    step();
    check_ifid("w2047", 32'h1000_07FF, 11'd2047, 11'd0, 1'b1);
    step();
    check_ifid("w0", 32'h1000_0000, 11'd0, 11'd1, 1'b1);

    // Test 6: asynchronous reset mid-run, branch request pending
    bus.branch_taken = 1'b1;
    bus.branch_target = 11'h155;
    #2 rst_n = 1'b0;
    #1;
    check("arst_addr", 32'(bus.pmem_addr), 32'd0);
    check_ifid("arst", 32'h0, 11'd0, 11'd0, 1'b0);
    bus.branch_taken = 1'b0;
    step();
    #2 rst_n = 1'b1;
    step();
    check("re1_valid", 32'(bus.if_valid), 32'd0);
    step();
    check_ifid("re2", 32'h1000_0000, 11'd0, 11'd1, 1'b1);
    step();
    check_ifid("re3", 32'h1000_0001, 11'd1, 11'd2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
